// File: rtl/nw_traceback_ctrl.sv
// rtl/nw_traceback_ctrl.sv - Needleman-Wunsch traceback sequencer: walks direction RAM arrows from (len_i,len_j) to (0,0)
// Emits one alignment op per step over a valid/ready handshake.
module nw_traceback_ctrl #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BitAddr:0]   len_i,
    input  logic [BitAddr:0]   len_j,
    output logic               en_traceB,
    output logic [BitAddr:0]   i_t,
    output logic [BitAddr:0]   j_t,
    input  logic [2:0]         symbol_out,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [1:0]         op_code,
    output logic [BitAddr:0]   op_i,
    output logic [BitAddr:0]   op_j,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [BitAddr+1:0] step_count
);

    localparam int AW = BitAddr + 1;
    localparam int CW = BitAddr + 2;

    localparam logic [2:0] SYM_DIAG = 3'b001;
    localparam logic [2:0] SYM_UP   = 3'b010;
    localparam logic [2:0] SYM_LEFT = 3'b100;

    localparam logic [1:0] OP_DIAG = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_LEFT = 2'b10;

    localparam logic [AW-1:0] LEN_MAX = AW'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CAPT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d, j_q, j_d;
    logic [1:0]    op_code_q, op_code_d;
    logic [AW-1:0] op_i_q, op_i_d, op_j_q, op_j_d;
    logic [CW-1:0] step_q, step_d;
    logic          error_q, error_d;

    logic          len_bad, len_zero, start_ok, accept;
    logic          sym_ok, mv_zero;
    logic [1:0]    sym_op;
    logic [AW-1:0] i_mv, j_mv;

    assign len_bad  = (len_i > LEN_MAX) || (len_j > LEN_MAX);
    assign len_zero = (len_i == '0) && (len_j == '0);
    assign start_ok = (state_q == S_IDLE) && start && !len_bad;
    assign accept   = (state_q == S_EMIT) && op_ready;

    // An arrow that would step off the matrix edge is as fatal as an unknown code.
    always_comb begin
        sym_ok = 1'b0;
        sym_op = OP_DIAG;
        case (symbol_out)
            SYM_DIAG: begin
                sym_op = OP_DIAG;
                sym_ok = (i_q != '0) && (j_q != '0);
            end
            SYM_UP: begin
                sym_op = OP_UP;
                sym_ok = (j_q != '0);
            end
            SYM_LEFT: begin
                sym_op = OP_LEFT;
                sym_ok = (i_q != '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        i_mv = i_q;
        j_mv = j_q;
        case (op_code_q)
            OP_DIAG: begin
                i_mv = i_q - AW'(1);
                j_mv = j_q - AW'(1);
            end
            OP_UP:   j_mv = j_q - AW'(1);
            OP_LEFT: i_mv = i_q - AW'(1);
            default: ;
        endcase
        mv_zero = (i_mv == '0) && (j_mv == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_bad)       state_d = S_ERR;
                    else if (len_zero) state_d = S_DONE;
                    else               state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_CAPT;
            S_CAPT:  state_d = sym_ok ? S_EMIT : S_ERR;
            S_EMIT: begin
                if (op_ready) state_d = mv_zero ? S_DONE : S_ISSUE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_traceB = (state_q == S_ISSUE);
        op_valid  = (state_q == S_EMIT);
        busy      = (state_q == S_ISSUE) || (state_q == S_CAPT) || (state_q == S_EMIT);
        done      = (state_q == S_DONE);
    end

    always_comb begin
        i_d       = i_q;
        j_d       = j_q;
        op_code_d = op_code_q;
        op_i_d    = op_i_q;
        op_j_d    = op_j_q;
        step_d    = step_q;
        error_d   = error_q;
        if (start_ok) begin
            i_d     = len_i;
            j_d     = len_j;
            step_d  = '0;
            error_d = 1'b0;
        end
        if ((state_q == S_CAPT) && sym_ok) begin
            op_code_d = sym_op;
            op_i_d    = i_q;
            op_j_d    = j_q;
        end
        if (accept) begin
            i_d    = i_mv;
            j_d    = j_mv;
            step_d = step_q + CW'(1);
        end
        if (state_d == S_ERR) error_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q       <= '0;
            j_q       <= '0;
            op_code_q <= '0;
            op_i_q    <= '0;
            op_j_q    <= '0;
            step_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            i_q       <= i_d;
            j_q       <= j_d;
            op_code_q <= op_code_d;
            op_i_q    <= op_i_d;
            op_j_q    <= op_j_d;
            step_q    <= step_d;
            error_q   <= error_d;
        end
    end

    assign i_t        = i_q;
    assign j_t        = j_q;
    assign op_code    = op_code_q;
    assign op_i       = op_i_q;
    assign op_j       = op_j_q;
    assign step_count = step_q;
    assign error      = error_q;

endmodule

// File: tb/tb_nw_traceback_ctrl.sv
// tb/tb_nw_traceback_ctrl.sv - self-checking bench for nw_traceback_ctrl
// Registered direction RAM model plus an op scoreboard checked on every handshake.
`timescale 1ns/1ps
module tb_nw_traceback_ctrl;

    localparam int N  = 128;
    localparam int BA = $clog2(N + 1);
    localparam int AW = BA + 1;
    localparam int CW = BA + 2;

    localparam logic [2:0] DIAG = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] LEFT = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len_i = '0, len_j = '0;
    logic          en_traceB;
    logic [AW-1:0] i_t, j_t;
    logic [2:0]    symbol_out = 3'b000;
    logic          op_valid;
    logic          op_ready = 1'b1;
    logic [1:0]    op_code;
    logic [AW-1:0] op_i, op_j;
    logic          busy, done, error;
    logic [CW-1:0] step_count;

    nw_traceback_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .len_i(len_i), .len_j(len_j),
        .en_traceB(en_traceB), .i_t(i_t), .j_t(j_t), .symbol_out(symbol_out),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_i(op_i), .op_j(op_j), .busy(busy), .done(done), .error(error),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    logic [2:0] dir_mem [0:N][0:N];

    always @(posedge clk) begin
        if (en_traceB) symbol_out <= dir_mem[i_t][j_t];
    end

    typedef struct {
        logic          en;
        logic [AW-1:0] it, jt;
        logic          valid;
        logic [1:0]    code;
        logic [AW-1:0] oi, oj;
        logic          dn, err, bsy;
        logic [CW-1:0] steps;
    } cyc_t;

    cyc_t              log_q[$];
    logic [2*AW+1:0]   exp_q[$];
    logic [2*AW+1:0]   mon_got, mon_exp;
    int                checks = 0;
    int                errors = 0;
    int                stall_left = 0;
    bit                timeout;

    // Scoreboard: every accepted op must match the next expected {code, i, j}.
    always @(negedge clk) begin
        if (!rst && op_valid && op_ready) begin
            checks++;
            mon_got = {op_code, op_i, op_j};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL op_unexpected: got code=%b at (%0d,%0d), required no op", op_code, op_i, op_j);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL op_match: got code=%b (%0d,%0d), required code=%b (%0d,%0d)",
                             op_code, op_i, op_j, mon_exp[2*AW+1:2*AW], mon_exp[2*AW-1:AW], mon_exp[AW-1:0]);
                end
            end
        end
    end

    function automatic logic [2*AW+1:0] mk_op(input logic [1:0] c, input int i, input int j);
        return {c, AW'(i), AW'(j)};
    endfunction

    task automatic pulse_start(input int li, input int lj);
        @(negedge clk);
        len_i = AW'(li);
        len_j = AW'(lj);
        start = 1'b1;
        @(posedge clk);
    endtask

    // Records cycle k (k=1 is the cycle after the start edge) into log_q[k-1].
    task automatic observe(input int budget);
        int   k;
        int   tail;
        bit   term;
        cyc_t c;
        log_q.delete();
        k = 0; tail = 0; term = 0;
        while (k < budget && !(term && tail >= 3)) begin
            #1;
            start = 1'b0;
            if (op_valid && stall_left > 0) begin
                op_ready = 1'b0;
                stall_left--;
            end else begin
                op_ready = 1'b1;
            end
            @(negedge clk);
            c.en = en_traceB; c.it = i_t; c.jt = j_t; c.valid = op_valid;
            c.code = op_code; c.oi = op_i; c.oj = op_j;
            c.dn = done; c.err = error; c.bsy = busy; c.steps = step_count;
            log_q.push_back(c);
            if (term) tail++;
            else if (done || error) term = 1;
            k++;
            @(posedge clk);
        end
        timeout = !term;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({en_traceB, op_valid, busy, done, error} !== 5'b0 || step_count !== '0 ||
            op_code !== 2'b00 || op_i !== '0 || op_j !== '0 || i_t !== '0 || j_t !== '0) begin
            errors++;
            $display("FAIL reset_outputs: en=%b valid=%b busy=%b done=%b err=%b steps=%0d, required all 0",
                     en_traceB, op_valid, busy, done, error, step_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_diag();
        dir_mem[1][1] = DIAG;
        dir_mem[2][2] = DIAG;
        exp_q.push_back(mk_op(2'b00, 2, 2));
        exp_q.push_back(mk_op(2'b00, 1, 1));
        pulse_start(2, 2);
        observe(100);
        checks++;
        if (timeout) begin errors++; $display("FAIL diag_timeout: no done/error, required done"); end
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (log_q[k-1].en !== (k == 1 || k == 4) || log_q[k-1].valid !== (k == 3 || k == 6) ||
                log_q[k-1].dn !== (k == 7)) begin
                errors++;
                $display("FAIL diag_timing cycle %0d: en=%b valid=%b done=%b, required en=%b valid=%b done=%b",
                         k, log_q[k-1].en, log_q[k-1].valid, log_q[k-1].dn,
                         (k == 1 || k == 4), (k == 3 || k == 6), (k == 7));
            end
        end
        checks++;
        if (log_q[0].it !== AW'(2) || log_q[0].jt !== AW'(2) || log_q[3].it !== AW'(1) || log_q[3].jt !== AW'(1)) begin
            errors++;
            $display("FAIL diag_addr: reads (%0d,%0d),(%0d,%0d), required (2,2),(1,1)",
                     log_q[0].it, log_q[0].jt, log_q[3].it, log_q[3].jt);
        end
        checks++;
        if (log_q[6].steps !== CW'(2)) begin
            errors++; $display("FAIL diag_steps: got %0d, required 2", log_q[6].steps);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL diag_ops_left: %0d ops not produced, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_left_path();
        int nrd;
        int dcyc;
        for (int i = 1; i <= N; i++) dir_mem[i][0] = LEFT;
        for (int j = 1; j <= N; j++) dir_mem[0][j] = UP;
        dir_mem[3][1] = LEFT;
        dir_mem[2][1] = DIAG;
        exp_q.push_back(mk_op(2'b10, 3, 1));
        exp_q.push_back(mk_op(2'b00, 2, 1));
        exp_q.push_back(mk_op(2'b10, 1, 0));
        pulse_start(3, 1);
        observe(100);
        nrd = 0; dcyc = 0;
        foreach (log_q[k]) begin
            if (log_q[k].en === 1'b1) nrd++;
            if (log_q[k].dn === 1'b1 && dcyc == 0) dcyc = k + 1;
        end
        checks++;
        if (timeout || nrd != 3 || dcyc != 10) begin
            errors++;
            $display("FAIL left_path_run: timeout=%0d reads=%0d done_cycle=%0d, required 0/3/10", timeout, nrd, dcyc);
        end
        checks++;
        if (log_q[9].steps !== CW'(3)) begin
            errors++; $display("FAIL left_path_steps: got %0d, required 3", log_q[9].steps);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL left_path_ops_left: %0d ops not produced, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stall();
        int dcyc;
        exp_q.push_back(mk_op(2'b00, 2, 2));
        exp_q.push_back(mk_op(2'b00, 1, 1));
        stall_left = 4;
        pulse_start(2, 2);
        observe(100);
        for (int k = 3; k <= 7; k++) begin
            checks++;
            if (log_q[k-1].valid !== 1'b1 || log_q[k-1].code !== 2'b00 || log_q[k-1].oi !== AW'(2) ||
                log_q[k-1].oj !== AW'(2) || log_q[k-1].it !== AW'(2) || log_q[k-1].jt !== AW'(2)) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: valid=%b code=%b op=(%0d,%0d) rd=(%0d,%0d), required 1/00/(2,2)/(2,2)",
                         k, log_q[k-1].valid, log_q[k-1].code, log_q[k-1].oi, log_q[k-1].oj, log_q[k-1].it, log_q[k-1].jt);
            end
        end
        dcyc = 0;
        foreach (log_q[k]) if (log_q[k].dn === 1'b1 && dcyc == 0) dcyc = k + 1;
        checks++;
        if (timeout || dcyc != 11 || log_q[7].en !== 1'b1 || log_q[10].steps !== CW'(2)) begin
            errors++;
            $display("FAIL stall_done: timeout=%0d done_cycle=%0d read8=%b steps=%0d, required 0/11/1/2",
                     timeout, dcyc, log_q[7].en, log_q[10].steps);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL stall_ops_left: %0d ops not produced, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_zero_len();
        int nrd;
        int nbusy;
        pulse_start(0, 0);
        observe(20);
        nrd = 0; nbusy = 0;
        foreach (log_q[k]) begin
            if (log_q[k].en !== 1'b0) nrd++;
            if (log_q[k].bsy !== 1'b0) nbusy++;
        end
        checks++;
        if (log_q[0].dn !== 1'b1 || log_q[0].steps !== '0 || nrd != 0 || nbusy != 0) begin
            errors++;
            $display("FAIL zero_len: done1=%b steps=%0d reads=%0d busy_cycles=%0d, required 1/0/0/0",
                     log_q[0].dn, log_q[0].steps, nrd, nbusy);
        end
    endtask

    task automatic test_bad_len();
        int nrd;
        int nbusy;
        pulse_start(N + 1, 1);
        observe(20);
        nrd = 0; nbusy = 0;
        foreach (log_q[k]) begin
            if (log_q[k].en !== 1'b0) nrd++;
            if (log_q[k].bsy !== 1'b0) nbusy++;
        end
        checks++;
        if (log_q[0].err !== 1'b1 || nrd != 0 || nbusy != 0) begin
            errors++;
            $display("FAIL bad_len: err1=%b reads=%0d busy_cycles=%0d, required 1/0/0", log_q[0].err, nrd, nbusy);
        end
        checks++;
        if (log_q[log_q.size()-1].err !== 1'b1) begin
            errors++; $display("FAIL bad_len_sticky: error=%b, required 1", log_q[log_q.size()-1].err);
        end
    endtask

    task automatic test_bad_symbol(input int li, input int lj, input logic [2:0] sym);
        int nrd;
        int nval;
        dir_mem[li][lj] = sym;
        pulse_start(li, lj);
        observe(30);
        nrd = 0; nval = 0;
        foreach (log_q[k]) begin
            if (log_q[k].en !== 1'b0) nrd++;
            if (log_q[k].valid !== 1'b0) nval++;
        end
        checks++;
        if (log_q[0].err !== 1'b0 || log_q[1].err !== 1'b0 || log_q[2].err !== 1'b1 || nrd != 1 || nval != 0) begin
            errors++;
            $display("FAIL bad_symbol (%0d,%0d)=%b: err c1/c2/c3=%b%b%b reads=%0d valids=%0d, required 001/1/0",
                     li, lj, sym, log_q[0].err, log_q[1].err, log_q[2].err, nrd, nval);
        end
    endtask

    task automatic test_rst_mid_run();
        int seen;
        bit hit;
        for (int d = 1; d <= 5; d++) dir_mem[d][d] = DIAG;
        exp_q.push_back(mk_op(2'b00, 5, 5));
        exp_q.push_back(mk_op(2'b00, 4, 4));
        pulse_start(5, 5);
        seen = 0; hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            #1;
            start = 1'b0;
            op_ready = !(op_valid && seen == 2);
            @(negedge clk);
            if (op_valid && op_ready) seen++;
            else if (op_valid) hit = 1;
            if (!hit) @(posedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rst_reach_emit: third EMIT not reached, required reached"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({en_traceB, op_valid, busy, done, error} !== 5'b0 || step_count !== '0 ||
            op_code !== 2'b00 || op_i !== '0 || op_j !== '0 || i_t !== '0 || j_t !== '0) begin
            errors++;
            $display("FAIL rst_mid_run: en=%b valid=%b busy=%b done=%b err=%b steps=%0d op=(%0d,%0d), required all 0",
                     en_traceB, op_valid, busy, done, error, step_count, op_i, op_j);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rst_ops_before: %0d ops not produced, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        rst = 1'b0;
        op_ready = 1'b1;
        exp_q.push_back(mk_op(2'b00, 2, 2));
        exp_q.push_back(mk_op(2'b00, 1, 1));
        pulse_start(2, 2);
        observe(100);
        checks++;
        if (timeout || log_q[0].steps !== '0 || log_q[3].steps !== CW'(1) || log_q[6].dn !== 1'b1 ||
            log_q[6].steps !== CW'(2)) begin
            errors++;
            $display("FAIL rst_rerun: timeout=%0d steps c1/c4/c7=%0d/%0d/%0d done7=%b, required 0 0/1/2 1",
                     timeout, log_q[0].steps, log_q[3].steps, log_q[6].steps, log_q[6].dn);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rst_rerun_ops_left: %0d ops not produced, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        for (int i = 0; i <= N; i++)
            for (int j = 0; j <= N; j++)
                dir_mem[i][j] = 3'b000;
        test_reset();
        test_diag();
        test_left_path();
        test_stall();
        test_zero_len();
        test_bad_len();
        test_bad_symbol(2, 2, 3'b011);
        test_bad_symbol(1, 0, UP);
        dir_mem[2][2] = DIAG;
        test_rst_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
